// File: rtl/reorder_buffer_pkg.sv
// Shared widths and the per-entry control packing for the reorder buffer.
// Result data is stored beside this packing so DATA_WIDTH stays a free parameter.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DATA_WIDTH = 16;
  localparam int unsigned ROB_TAG_WIDTH  = 3;
  localparam int unsigned ROB_DEST_WIDTH = 3;

  typedef logic [ROB_DEST_WIDTH-1:0] dest_reg_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    logic      we;
    logic      ovf;
    dest_reg_t dest_reg;
  } rob_ctrl_t;

  // An overflowing instruction must never reach the register file.
  function automatic logic rob_commit_we(rob_ctrl_t e);
    return e.we & ~e.ovf;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode, writeback and commit signals of the reorder buffer.
// master = pipeline side, slave = the buffer itself.
interface reorder_buffer_if import reorder_buffer_pkg::*; #(
  parameter int unsigned DATA_WIDTH = ROB_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH  = ROB_TAG_WIDTH
) ();

  logic                  flush;
  logic                  alloc_valid;
  dest_reg_t             alloc_destReg;
  logic                  alloc_we;
  logic                  alloc_ready;
  logic [TAG_WIDTH-1:0]  tail_rob;
  logic                  wb_valid;
  logic [TAG_WIDTH-1:0]  wb_tag;
  logic [DATA_WIDTH-1:0] wb_result;
  logic                  wb_ovf;
  logic                  commit_valid;
  dest_reg_t             commit_destReg;
  logic [DATA_WIDTH-1:0] commit_data;
  logic                  commit_we;
  logic                  commit_exception;
  logic                  empty;

  modport master (
    output flush, alloc_valid, alloc_destReg, alloc_we, wb_valid, wb_tag, wb_result, wb_ovf,
    input  alloc_ready, tail_rob, commit_valid, commit_destReg, commit_data, commit_we,
           commit_exception, empty
  );

  modport slave (
    input  flush, alloc_valid, alloc_destReg, alloc_we, wb_valid, wb_tag, wb_result, wb_ovf,
    output alloc_ready, tail_rob, commit_valid, commit_destReg, commit_data, commit_we,
           commit_exception, empty
  );

endinterface

// File: rtl/rob_entry_array.sv
// Per-entry storage of the reorder buffer: alloc write, writeback write, head read, clear-all.
// Clear-all has priority over every other write on the same edge.
module rob_entry_array import reorder_buffer_pkg::*; #(
  parameter int unsigned DATA_WIDTH = ROB_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH  = ROB_TAG_WIDTH,
  localparam int unsigned DEPTH     = 2 ** TAG_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_alloc_en,
  input  logic [TAG_WIDTH-1:0]  i_alloc_idx,
  input  dest_reg_t             i_alloc_dest,
  input  logic                  i_alloc_we,
  input  logic                  i_wb_en,
  input  logic [TAG_WIDTH-1:0]  i_wb_idx,
  input  logic [DATA_WIDTH-1:0] i_wb_result,
  input  logic                  i_wb_ovf,
  input  logic                  i_retire_en,
  input  logic [TAG_WIDTH-1:0]  i_head_idx,
  output rob_ctrl_t             o_head_ctrl,
  output logic [DATA_WIDTH-1:0] o_head_result,
  output logic [DEPTH-1:0]      o_valid
);

  rob_ctrl_t             r_ctrl   [DEPTH];
  logic [DATA_WIDTH-1:0] r_result [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctrl[i]   <= '0;
        r_result[i] <= '0;
      end
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctrl[i].valid <= 1'b0;
        r_ctrl[i].done  <= 1'b0;
      end
    end else begin
      if (i_retire_en) begin
        r_ctrl[i_head_idx].valid <= 1'b0;
      end
      if (i_alloc_en) begin
        r_ctrl[i_alloc_idx] <= '{valid: 1'b1, done: 1'b0, we: i_alloc_we, ovf: 1'b0,
                                 dest_reg: i_alloc_dest};
      end
      if (i_wb_en) begin
        r_ctrl[i_wb_idx].done <= 1'b1;
        r_ctrl[i_wb_idx].ovf  <= i_wb_ovf;
        r_result[i_wb_idx]    <= i_wb_result;
      end
    end
  end

  always_comb begin
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_valid[i] = r_ctrl[i].valid;
    end
  end

  assign o_head_ctrl   = r_ctrl[i_head_idx];
  assign o_head_result = r_result[i_head_idx];

endmodule

// File: rtl/reorder_buffer.sv
// In-order completion buffer: allocates tags at decode, accepts tagged writeback out of
// order, retires one entry per cycle in allocation order; an overflow retire flushes all.
module reorder_buffer import reorder_buffer_pkg::*; #(
  parameter int unsigned DATA_WIDTH = ROB_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH  = ROB_TAG_WIDTH
) (
  input logic              clk,
  input logic              reset,
  reorder_buffer_if.slave  rob_bus
);

  localparam int unsigned         DEPTH      = 2 ** TAG_WIDTH;
  localparam logic [TAG_WIDTH:0]  FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);

  logic [TAG_WIDTH-1:0]  r_head;
  logic [TAG_WIDTH-1:0]  r_tail;
  logic [TAG_WIDTH:0]    r_count;
  logic                  r_commit_valid;
  dest_reg_t             r_commit_dest;
  logic [DATA_WIDTH-1:0] r_commit_data;
  logic                  r_commit_we;
  logic                  r_commit_exc;

  rob_ctrl_t             w_head_ctrl;
  logic [DATA_WIDTH-1:0] w_head_result;
  logic [DEPTH-1:0]      w_valid;
  logic                  w_alloc_ready;
  logic                  w_alloc;
  logic                  w_wb;
  logic                  w_commit;
  logic                  w_exc;
  logic                  w_clear;

  // Ready uses the pre-edge count, so a full buffer cannot refill on the edge it commits.
  assign w_alloc_ready = (r_count < FULL_COUNT) && !rob_bus.flush;
  assign w_alloc       = rob_bus.alloc_valid && w_alloc_ready;
  assign w_wb          = rob_bus.wb_valid && w_valid[rob_bus.wb_tag];
  assign w_commit      = w_head_ctrl.valid && w_head_ctrl.done && !rob_bus.flush;
  assign w_exc         = w_commit && w_head_ctrl.ovf;
  assign w_clear       = rob_bus.flush || w_exc;

  rob_entry_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_entries (
    .i_clk         (clk),
    .i_rst_n       (reset),
    .i_clear       (w_clear),
    .i_alloc_en    (w_alloc),
    .i_alloc_idx   (r_tail),
    .i_alloc_dest  (rob_bus.alloc_destReg),
    .i_alloc_we    (rob_bus.alloc_we),
    .i_wb_en       (w_wb),
    .i_wb_idx      (rob_bus.wb_tag),
    .i_wb_result   (rob_bus.wb_result),
    .i_wb_ovf      (rob_bus.wb_ovf),
    .i_retire_en   (w_commit),
    .i_head_idx    (r_head),
    .o_head_ctrl   (w_head_ctrl),
    .o_head_result (w_head_result),
    .o_valid       (w_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_commit) begin
        r_head <= r_head + TAG_WIDTH'(1);
      end
      if (w_alloc) begin
        r_tail <= r_tail + TAG_WIDTH'(1);
      end
      r_count <= r_count + (TAG_WIDTH + 1)'(w_alloc) - (TAG_WIDTH + 1)'(w_commit);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_commit_valid <= 1'b0;
      r_commit_dest  <= '0;
      r_commit_data  <= '0;
      r_commit_we    <= 1'b0;
      r_commit_exc   <= 1'b0;
    end else begin
      r_commit_valid <= w_commit;
      if (w_commit) begin
        r_commit_dest <= w_head_ctrl.dest_reg;
        r_commit_data <= w_head_result;
        r_commit_we   <= rob_commit_we(w_head_ctrl);
        r_commit_exc  <= w_head_ctrl.ovf;
      end
    end
  end

  assign rob_bus.alloc_ready      = w_alloc_ready;
  assign rob_bus.tail_rob         = r_tail;
  assign rob_bus.empty            = (r_count == '0);
  assign rob_bus.commit_valid     = r_commit_valid;
  assign rob_bus.commit_destReg   = r_commit_dest;
  assign rob_bus.commit_data      = r_commit_data;
  assign rob_bus.commit_we        = r_commit_we;
  assign rob_bus.commit_exception = r_commit_exc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: ordering, full/wrap, overflow exception, flush,
// stray writeback and asynchronous reset, with hand-computed expectations.
module tb_reorder_buffer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  reorder_buffer_if #(.DATA_WIDTH(16), .TAG_WIDTH(3)) rob_bus ();

  reorder_buffer #(.DATA_WIDTH(16), .TAG_WIDTH(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .rob_bus (rob_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic av, input logic [2:0] ad, input logic awe, input logic wv,
                        input logic [2:0] wt, input logic [15:0] wr, input logic wo,
                        input logic fl);
    rob_bus.alloc_valid   = av;
    rob_bus.alloc_destReg = ad;
    rob_bus.alloc_we      = awe;
    rob_bus.wb_valid      = wv;
    rob_bus.wb_tag        = wt;
    rob_bus.wb_result     = wr;
    rob_bus.wb_ovf        = wo;
    rob_bus.flush         = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic av, input logic [2:0] ad, input logic awe, input logic wv,
                     input logic [2:0] wt, input logic [15:0] wr, input logic wo,
                     input logic fl);
    set_in(av, ad, awe, wv, wt, wr, wo, fl);
    tick();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic check_commit(input string tag, input logic [2:0] dest, input logic [15:0] data,
                              input logic we, input logic exc);
    check_eq({tag, ".valid"}, rob_bus.commit_valid, 1);
    check_eq({tag, ".dest"}, rob_bus.commit_destReg, dest);
    check_eq({tag, ".data"}, rob_bus.commit_data, data);
    check_eq({tag, ".we"}, rob_bus.commit_we, we);
    check_eq({tag, ".exc"}, rob_bus.commit_exception, exc);
  endtask

  task automatic pulse_reset();
    set_in(0, 0, 0, 0, 0, 16'h0, 0, 0);
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    set_in(0, 0, 0, 0, 0, 16'h0, 0, 0);
    #2;
    check_eq("rst.commit_valid", rob_bus.commit_valid, 0);
    check_eq("rst.commit_data", rob_bus.commit_data, 0);
    check_eq("rst.empty", rob_bus.empty, 1);
    check_eq("rst.tail", rob_bus.tail_rob, 0);
    check_eq("rst.ready", rob_bus.alloc_ready, 1);
    tick();
    reset = 1'b1;

    // Out-of-order writeback, in-order retire
    check_eq("ooo.tail0", rob_bus.tail_rob, 0);
    cyc(1, 3'd1, 1, 0, 0, 16'h0, 0, 0);
    check_eq("ooo.tail1", rob_bus.tail_rob, 1);
    cyc(1, 3'd2, 1, 0, 0, 16'h0, 0, 0);
    cyc(1, 3'd3, 1, 0, 0, 16'h0, 0, 0);
    check_eq("ooo.tail3", rob_bus.tail_rob, 3);
    cyc(0, 0, 0, 1, 3'd2, 16'h0033, 0, 0);
    check_eq("ooo.no_commit_a", rob_bus.commit_valid, 0);
    cyc(0, 0, 0, 1, 3'd0, 16'h0011, 0, 0);
    check_eq("ooo.no_commit_b", rob_bus.commit_valid, 0);
    cyc(0, 0, 0, 1, 3'd1, 16'h0022, 0, 0);
    check_commit("ooo.c0", 3'd1, 16'h0011, 1, 0);
    idle_cyc();
    check_commit("ooo.c1", 3'd2, 16'h0022, 1, 0);
    idle_cyc();
    check_commit("ooo.c2", 3'd3, 16'h0033, 1, 0);
    idle_cyc();
    check_eq("ooo.done_valid", rob_bus.commit_valid, 0);
    check_eq("ooo.empty", rob_bus.empty, 1);

    // Full, ignored ninth alloc, wrap, alloc+commit on one edge
    pulse_reset();
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), 1, 0, 0, 16'h0, 0, 0);
    check_eq("full.ready", rob_bus.alloc_ready, 0);
    check_eq("full.tail", rob_bus.tail_rob, 0);
    check_eq("full.empty", rob_bus.empty, 0);
    cyc(1, 3'd7, 1, 0, 0, 16'h0, 0, 0);
    check_eq("full.ninth_tail", rob_bus.tail_rob, 0);
    check_eq("full.ninth_ready", rob_bus.alloc_ready, 0);
    cyc(1, 3'd7, 1, 1, 3'd0, 16'h00A0, 0, 0);
    check_eq("full.wb_no_commit", rob_bus.commit_valid, 0);
    cyc(1, 3'd7, 1, 0, 0, 16'h0, 0, 0);
    check_commit("full.c0", 3'd0, 16'h00A0, 1, 0);
    check_eq("full.ready_after", rob_bus.alloc_ready, 1);
    check_eq("full.tail_blocked", rob_bus.tail_rob, 0);
    cyc(1, 3'd5, 1, 1, 3'd1, 16'h00A1, 0, 0);
    check_eq("wrap.tail", rob_bus.tail_rob, 1);
    check_eq("wrap.ready", rob_bus.alloc_ready, 0);
    check_eq("wrap.no_commit", rob_bus.commit_valid, 0);
    idle_cyc();
    check_commit("wrap.c1", 3'd1, 16'h00A1, 1, 0);
    cyc(0, 0, 0, 1, 3'd2, 16'h00A2, 0, 0);
    cyc(1, 3'd6, 1, 0, 0, 16'h0, 0, 0);
    check_commit("same.c2", 3'd2, 16'h00A2, 1, 0);
    check_eq("same.ready", rob_bus.alloc_ready, 1);
    check_eq("same.tail", rob_bus.tail_rob, 2);

    // Overflow exception
    pulse_reset();
    cyc(1, 3'd1, 1, 0, 0, 16'h0, 0, 0);
    cyc(1, 3'd2, 1, 0, 0, 16'h0, 0, 0);
    cyc(1, 3'd3, 1, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 0, 1, 3'd0, 16'h0010, 0, 0);
    cyc(0, 0, 0, 1, 3'd1, 16'h0020, 1, 0);
    check_commit("ovf.c0", 3'd1, 16'h0010, 1, 0);
    cyc(0, 0, 0, 1, 3'd2, 16'h0030, 0, 0);
    check_commit("ovf.c1", 3'd2, 16'h0020, 0, 1);
    check_eq("ovf.empty", rob_bus.empty, 1);
    check_eq("ovf.tail", rob_bus.tail_rob, 0);
    idle_cyc();
    check_eq("ovf.no_c2_a", rob_bus.commit_valid, 0);
    idle_cyc();
    check_eq("ovf.no_c2_b", rob_bus.commit_valid, 0);

    // Flush with simultaneous alloc and writeback
    pulse_reset();
    for (int i = 0; i < 4; i++) cyc(1, 3'(i + 1), 1, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 0, 1, 3'd1, 16'h0B01, 0, 0);
    cyc(0, 0, 0, 1, 3'd2, 16'h0B02, 0, 0);
    set_in(1, 3'd6, 1, 1, 3'd0, 16'h0B00, 0, 1);
    #1;
    check_eq("flush.ready_low", rob_bus.alloc_ready, 0);
    tick();
    check_eq("flush.no_commit", rob_bus.commit_valid, 0);
    check_eq("flush.empty", rob_bus.empty, 1);
    check_eq("flush.tail", rob_bus.tail_rob, 0);
    idle_cyc();
    check_eq("flush.no_commit_after", rob_bus.commit_valid, 0);
    cyc(1, 3'd4, 1, 0, 0, 16'h0, 0, 0);
    check_eq("flush.next_tail", rob_bus.tail_rob, 1);

    // Stray writeback to unallocated tag 5
    cyc(0, 0, 0, 1, 3'd5, 16'hDEAD, 0, 0);
    check_eq("stray.no_commit", rob_bus.commit_valid, 0);
    check_eq("stray.tail", rob_bus.tail_rob, 1);
    check_eq("stray.empty", rob_bus.empty, 0);
    idle_cyc();
    check_eq("stray.no_commit_b", rob_bus.commit_valid, 0);

    // Asynchronous reset with a committable head pending
    cyc(0, 0, 0, 1, 3'd0, 16'h0055, 0, 0);
    set_in(0, 0, 0, 0, 0, 16'h0, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    check_eq("mrst.commit_valid", rob_bus.commit_valid, 0);
    check_eq("mrst.commit_dest", rob_bus.commit_destReg, 0);
    check_eq("mrst.empty", rob_bus.empty, 1);
    check_eq("mrst.tail", rob_bus.tail_rob, 0);
    check_eq("mrst.ready", rob_bus.alloc_ready, 1);
    reset = 1'b1;
    tick();
    check_eq("mrst.lost", rob_bus.commit_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
